parity_tx_ctrl: RTL and testbench

Serial even-parity frame controller. It accepts a parallel data word over a valid/ready handshake and shifts it out LSB first, one bit per accepted beat. It then appends one even-parity bit, the XOR of all data bits. The block sits between a parallel producer and a 1-bit serial link, and owns the sequencing of the parity function that the combinational XOR generator performs in one shot.

---
 rtl/parity_tx_ctrl.sv | 115 +++++++++++
 tb/tb_parity_tx_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_tx_ctrl.sv
// Purpose: serialises a DATA_W-bit word LSB first and appends one even-parity bit (XOR of all data bits).
// Latency: bit 0 is presented the cycle after accept; frame is DATA_W+1 beats; next accept DATA_W+2 cycles later at best.
// Backpressure: ser_ready=0 freezes the current bit; in_ready stays low for the whole frame (no queuing).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     parallel word handshake, in_data sampled only at the accept edge
//   ser_out/ser_valid     serial bit and its qualifier, taken when ser_ready=1 at a rising edge
//   ser_last              current bit is the parity bit closing the frame
//   busy                  frame in progress (inverse of in_ready)
module parity_tx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic              busy
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                acc_q, acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_ready) begin
                    acc_d   = acc_q ^ shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    if (cnt_q == CNT_LAST) begin
                        // Counter parks at its last value so it never wraps.
                        state_d = PARITY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (ser_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on registered state only; no input reaches an output combinationally.
    always_comb begin
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_last  = 1'b0;
        ser_out   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = shreg_q[0];
            end
            PARITY: begin
                ser_valid = 1'b1;
                ser_last  = 1'b1;
                ser_out   = acc_q;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
        busy = ~in_ready;
    end

endmodule

// File: tb/tb_parity_tx_ctrl.sv
module tb_parity_tx_ctrl;

    logic       clk;
    logic       rst_n;
    // 8-bit instance
    logic       in_valid, in_ready, ser_out, ser_valid, ser_ready, ser_last, busy;
    logic [7:0] in_data;
    // 3-bit instance
    logic       in_valid3, in_ready3, ser_out3, ser_valid3, ser_ready3, ser_last3, busy3;
    logic [2:0] in_data3;

    int checks = 0;
    int errors = 0;

    // Expected beats: {last, bit}
    logic [1:0] q8[$];
    logic [1:0] q3[$];

    parity_tx_ctrl #(.DATA_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready),
        .ser_last(ser_last), .busy(busy)
    );

    parity_tx_ctrl #(.DATA_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .ser_out(ser_out3), .ser_valid(ser_valid3), .ser_ready(ser_ready3),
        .ser_last(ser_last3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitors: compare the presented bit every valid cycle, pop on transfer.
    always @(negedge clk) begin
        if (rst_n && ser_valid) begin
            if (q8.size() == 0) begin
                chk("unexp_beat8", 32'(1), 32'(0));
            end else begin
                chk("ser_out8", 32'(ser_out), 32'(q8[0][0]));
                chk("ser_last8", 32'(ser_last), 32'(q8[0][1]));
                if (ser_ready) void'(q8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ser_valid3) begin
            if (q3.size() == 0) begin
                chk("unexp_beat3", 32'(1), 32'(0));
            end else begin
                chk(q3[0][1] ? "parity3" : "ser_out3", 32'(ser_out3), 32'(q3[0][0]));
                chk("ser_last3", 32'(ser_last3), 32'(q3[0][1]));
                if (ser_ready3) void'(q3.pop_front());
            end
        end
    end

    // Accept one word on the 8-bit instance; returns #1 after the accept edge.
    task automatic send8(input logic [7:0] w);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_rdy8", 32'(in_ready), 32'(1));
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 8; i++) q8.push_back({1'b0, w[i]});
        q8.push_back({1'b1, ^w});
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Count edges until in_ready returns; compare against the expected count.
    task automatic wait_done8(input string tag, input int exp_edges);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk(tag, 32'(n), 32'(exp_edges));
    endtask

    initial begin
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        ser_ready  = 1'b1;
        in_valid3  = 1'b0;
        in_data3   = 3'd0;
        ser_ready3 = 1'b1;

        // Asynchronous reset before any clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ser_valid", 32'(ser_valid), 32'(0));
        chk("rst_ser_last", 32'(ser_last), 32'(0));
        chk("rst_ser_out", 32'(ser_out), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 8'hB4, no backpressure
        send8(8'hB4);
        wait_done8("len_b4", 9);

        // 8'h07 then 8'h00 back-to-back at the first in_ready
        send8(8'h07);
        wait_done8("len_07", 9);
        send8(8'h00);
        wait_done8("len_00", 9);

        // Stall 3 cycles while beat 3 (a 1) is presented
        send8(8'hB4);
        repeat (2) begin @(posedge clk); #1; end
        ser_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_vld", 32'(ser_valid), 32'(1));
            chk("stall_out", 32'(ser_out), 32'(1));
        end
        ser_ready = 1'b1;
        wait_done8("len_stall", 7);

        // in_valid with another word during a frame is ignored
        send8(8'h5A);
        repeat (2) begin @(posedge clk); #1; end
        chk("busy_rdy", 32'(in_ready), 32'(0));
        chk("busy_flag", 32'(busy), 32'(1));
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done8("len_busy", 6);

        // Reset while beat 4 is presented aborts the frame
        send8(8'hB4);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ser_valid", 32'(ser_valid), 32'(0));
        chk("abort_ser_last", 32'(ser_last), 32'(0));
        chk("abort_ser_out", 32'(ser_out), 32'(0));
        chk("abort_in_ready", 32'(in_ready), 32'(1));
        chk("abort_busy", 32'(busy), 32'(0));
        q8.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            chk("post_abort_vld", 32'(ser_valid), 32'(0));
        end

        // DATA_W=3: every word, parity must equal a^b^c
        for (int w = 0; w < 8; w++) begin
            int n = 0;
            logic [2:0] wv;
            wv = 3'(w);
            while (!in_ready3 && n < 50) begin
                @(posedge clk); #1; n++;
            end
            chk("accept_rdy3", 32'(in_ready3), 32'(1));
            in_valid3 = 1'b1;
            in_data3  = wv;
            for (int i = 0; i < 3; i++) q3.push_back({1'b0, wv[i]});
            q3.push_back({1'b1, wv[0] ^ wv[1] ^ wv[2]});
            @(posedge clk); #1;
            in_valid3 = 1'b0;
            in_data3  = 3'($urandom);
            n = 0;
            while (!in_ready3 && n < 50) begin
                @(posedge clk); #1; n++;
            end
            chk("len3", 32'(n), 32'(4));
        end

        chk("q8_empty", 32'(q8.size()), 32'(0));
        chk("q3_empty", 32'(q3.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
